// File: rtl/gray_counter.sv
// Up/down binary counter with a registered reflected-Gray copy of the count,
// synchronous load, and one-cycle wrap/step pulses. All outputs come straight
// from flops.
module gray_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_bin,
    output logic [N-1:0] bin,
    output logic [N-1:0] gray,
    output logic         wrap,
    output logic         step
);

    localparam logic [N-1:0] one = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         step_q, step_d;

    // Next-state: load beats count beats hold; Gray is derived from the next
    // binary value so both registers always agree.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        step_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            step_d = 1'b1;
        end else if (en) begin
            step_d = 1'b1;
            if (up) begin
                bin_d  = bin_q + one;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - one;
                wrap_d = ~|bin_q;
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State registers; reset clears any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            step_q <= step_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;
    assign step = step_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector and property bench for gray_counter at N=4.
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    gray_counter #(.N(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] load_bin;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        logic       step;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] eb, input logic [3:0] eg,
                             input logic ew, input logic es);
        check({name, ".bin"}, {28'd0, bin}, {28'd0, eb});
        check({name, ".gray"}, {28'd0, gray}, {28'd0, eg});
        check({name, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
        check({name, ".step"}, {31'd0, step}, {31'd0, es});
    endtask

    task automatic drive(input logic l, input logic e, input logic u, input logic [3:0] lb);
        load = l; en = e; up = u; load_bin = lb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between edges.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] sweep_gray[16];
    logic [3:0] model_bin;
    logic [3:0] prev_gray;
    logic       model_wrap;
    logic       model_step;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        #2;
        check_all("por", 4'h0, 4'h0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        //              load  en    up    lbin   bin    gray   wrap  step
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h2, 4'h3, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'hA, 4'hA, 4'hF, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h5, 4'h5, 4'h7, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'h7, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'h3, 4'h6, 4'h5, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 4'h9, 4'h6, 4'h5, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h6, 4'h5, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 4'h6, 4'h6, 4'h5, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h6, 4'h5, 1'b0, 1'b0};

        sweep_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                       4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_bin);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].gray,
                      vecs[i].wrap, vecs[i].step);
        end

        // Full up sweep from reset.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_all($sformatf("sweep%0d", i), 4'(i + 1), sweep_gray[i],
                      (i == 15) ? 1'b1 : 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        tick();
        check_all("sweep_end", 4'h0, 4'h0, 1'b0, 1'b0);

        // Down wrap straight out of reset.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        tick();
        check_all("downwrap", 4'hF, 4'h8, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        check_all("downwrap_end", 4'hF, 4'h8, 1'b0, 1'b0);

        // Async reset mid-count with a load pending.
        drive(1'b1, 1'b0, 1'b0, 4'h4);
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        tick();
        check_all("pre_arst", 4'h5, 4'h7, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'hC);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all("arst_immediate", 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check_all("arst_held", 4'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("arst_release", 4'h1, 4'h1, 1'b0, 1'b1);

        // Random en/up stream with an independent model.
        do_reset();
        model_bin = 4'h0;
        for (int i = 0; i < 1200; i++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
            prev_gray  = gray;
            model_wrap = 1'b0;
            model_step = en;
            if (en) begin
                if (up) begin
                    model_wrap = (model_bin == 4'hF);
                    model_bin  = model_bin + 4'h1;
                end else begin
                    model_wrap = (model_bin == 4'h0);
                    model_bin  = model_bin - 4'h1;
                end
            end
            tick();
            check("rnd.bin", {28'd0, bin}, {28'd0, model_bin});
            check("rnd.gray_enc", {28'd0, gray}, {28'd0, bin ^ (bin >> 1)});
            check("rnd.wrap", {31'd0, wrap}, {31'd0, model_wrap});
            check("rnd.step", {31'd0, step}, {31'd0, model_step});
            if (step) check("rnd.hamming", $countones(gray ^ prev_gray), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the counter width in bits; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit, meaning a count-step enable.
REQ-005 The block SHALL have port up, input, 1 bit, meaning direction: 1 counts up, 0 counts down.
REQ-006 The block SHALL have port load, input, 1 bit, meaning load load_bin this cycle.
REQ-007 The block SHALL have port load_bin, input, N bits, meaning the binary value to load.
REQ-008 The block SHALL have port bin, output, N bits, meaning the current count in binary (registered).
REQ-009 The block SHALL have port gray, output, N bits, meaning the current count in reflected Gray code (registered).
REQ-010 The block SHALL have port wrap, output, 1 bit, meaning a one-cycle pulse on count roll-over.
REQ-011 The block SHALL have port step, output, 1 bit, meaning a one-cycle pulse on any update of bin/gray.

Function
REQ-012 bin, gray, wrap and step SHALL all be driven directly from flops, with no combinational path from any input to any output.
REQ-013 gray SHALL equal bin XOR (bin >> 1) after every clock edge; the next Gray value is computed from the next binary value and registered on the same edge as bin.
REQ-014 Update priority per rising edge: load, then en, then hold.
REQ-015 When load=1, bin SHALL take load_bin and gray SHALL take its Gray encoding on that edge, regardless of en and up.
REQ-016 When load=0, en=1 and up=1, bin SHALL take (bin+1) mod 2^N.
REQ-017 When load=0, en=1 and up=0, bin SHALL take (bin-1) mod 2^N.
REQ-018 When load=0 and en=0, bin and gray SHALL hold their values.
REQ-019 Latency SHALL be one edge: inputs sampled at edge k appear on the outputs immediately after edge k.
REQ-020 wrap SHALL be 1 for exactly the cycle after an edge on which a counting step moved bin from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down); it SHALL be 0 otherwise.
REQ-021 A load SHALL never assert wrap, including a load of 0 while bin=2^N-1.
REQ-022 step SHALL be 1 for the cycle after any edge with load=1 or en=1, even when the loaded value equals the current value; it SHALL be 0 otherwise.
REQ-023 During counting (no load), consecutive gray values SHALL differ in exactly one bit, including across the wrap in either direction.
REQ-024 Changing direction between consecutive enabled edges SHALL simply reverse the sequence (e.g. N=4: bin 0101 up -> 0110, then down -> 0101), with no extra state.

Reset
REQ-025 While rst_n=0, the outputs SHALL be bin=0, gray=0, wrap=0 and step=0, applied immediately without waiting for clk.
REQ-026 Reset asserted mid-count SHALL discard any pending step or load, and SHALL clear wrap/step pulses in flight.
REQ-027 The first update after reset SHALL occur on the first rising edge at which rst_n=1 and load or en is 1.

Verification
REQ-028 Up sweep (N=4): from reset, hold en=1 and up=1 for 16 edges -> gray sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only after the 16th edge; step=1 every cycle.
REQ-029 Down wrap: from reset, one edge with en=1 and up=0 -> bin=1111, gray=1000, wrap=1 for one cycle.
REQ-030 Load priority: with bin=0011, apply load=1, load_bin=1010, en=1, up=1 -> bin=1010, gray=1111, wrap=0, step=1; then load_bin=0000 from 1111 with load=1 -> wrap=0.
REQ-031 Hold: with en=0 and load=0 for 5 edges at bin=0110 -> bin=0110, gray=0101, step=0 and wrap=0 throughout.
REQ-032 Async reset: with bin=0101 counting, drive rst_n low between edges -> all outputs 0 before the next edge; release rst_n with en=1 -> next edge gives bin=0001.
REQ-033 Property check: over a random en/up stream of at least 1000 cycles with no load -> every adjacent gray pair has Hamming distance 1 whenever step=1, and gray equals bin XOR (bin>>1) on every cycle.
